// File: rtl/lcd_host_ctrl_pkg.sv
// Shared types and constants for the LCD host controller.
package lcd_host_ctrl_pkg;

   localparam int unsigned IMG_W   = 8;
   localparam int unsigned IMG_PIX = 64;
   localparam int unsigned ADDR_W  = 6;

   // LCD_CTRL command codes
   typedef enum logic [2:0] {
      CmdWrite,
      CmdUp,
      CmdDown,
      CmdLeft,
      CmdRight,
      CmdAvg,
      CmdMirX,
      CmdMirY
   } cmd_e;

   // Host sequencing states
   typedef enum logic [2:0] {
      StLoad,
      StIdle,
      StIssue,
      StAck,
      StWait,
      StCapture,
      StDone
   } state_e;

   // Write counter saturates rather than wrapping
   function automatic logic [6:0] sat_inc7(input logic [6:0] v);
      return (v == 7'd127) ? v : v + 7'd1;
   endfunction

endpackage

// File: rtl/lcd_host_ctrl_cmd_fifo.sv
// Command queue: synchronous FIFO with extra-bit pointers for full/empty.
module lcd_host_ctrl_cmd_fifo #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rdata = mem_q[rptr_q[AW-1:0]];

   // Pointer advance; push and pop may share a cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push && !full) wptr_q <= wptr_q + PTR_ONE;
         if (pop && !empty) rptr_q <= rptr_q + PTR_ONE;
      end
   end

   // Storage is not reset; only the pointers define validity
   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/lcd_host_ctrl.sv
// Host side of LCD_CTRL: image ROM server, command feeder and IRB capture sink.
module lcd_host_ctrl
   import lcd_host_ctrl_pkg::*;
#(
   parameter int unsigned CMD_DEPTH   = 16,
   parameter int unsigned ACK_TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              img_wr_en,
   input  logic [ADDR_W-1:0] img_wr_addr,
   input  logic [IMG_W-1:0]  img_wr_data,
   input  logic [2:0]        host_cmd,
   input  logic              host_cmd_valid,
   output logic              host_cmd_ready,
   input  logic              IROM_EN,
   input  logic [ADDR_W-1:0] IROM_A,
   output logic [IMG_W-1:0]  IROM_Q,
   input  logic              busy,
   output logic [2:0]        cmd,
   output logic              cmd_valid,
   input  logic              IRB_RW,
   input  logic [ADDR_W-1:0] IRB_A,
   input  logic [IMG_W-1:0]  IRB_D,
   input  logic              done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [IMG_W-1:0]  rd_data,
   output logic [6:0]        write_count,
   output logic [15:0]       checksum,
   output logic              frame_done,
   output logic              frame_ok,
   output logic              ack_err,
   output logic              proto_err
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

   logic [IMG_W-1:0] img_q [IMG_PIX];
   logic [IMG_W-1:0] cap_q [IMG_PIX];
   logic [IMG_W-1:0] irom_data_q;

   state_e        state_q, state_d;
   logic [2:0]    cmd_q, cmd_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          ack_err_q, ack_err_d;
   logic          frame_done_q, frame_done_d;
   logic          proto_err_q;
   logic [6:0]    write_count_q;
   logic [15:0]   checksum_q;

   logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [2:0] fifo_head;
   logic       in_capture;

   assign in_capture     = (state_q == StCapture) || (state_q == StDone);
   assign host_cmd_ready = !fifo_full && !in_capture;
   assign fifo_push      = host_cmd_valid && host_cmd_ready;

   lcd_host_ctrl_cmd_fifo #(
      .WIDTH (3),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (host_cmd),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state: sequence one command at a time, then capture the written frame
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      timer_d      = timer_q;
      ack_err_d    = ack_err_q;
      frame_done_d = frame_done_q;
      fifo_pop     = 1'b0;
      unique case (state_q)
         StLoad: begin
            if (!busy) state_d = StIdle;
         end
         StIdle: begin
            // Load cmd on entry so it already equals the head during ISSUE
            if (!busy && !fifo_empty) begin
               state_d = StIssue;
               cmd_d   = fifo_head;
            end
         end
         StIssue: begin
            fifo_pop = 1'b1;
            timer_d  = '0;
            state_d  = StAck;
         end
         StAck: begin
            if (busy) begin
               state_d = (cmd_q == CmdWrite) ? StCapture : StWait;
            end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
               ack_err_d = 1'b1;
               state_d   = (cmd_q == CmdWrite) ? StCapture : StIdle;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         StWait: begin
            if (!busy) state_d = StIdle;
         end
         StCapture: begin
            if (done) begin
               state_d      = StDone;
               frame_done_d = 1'b1;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: state_d = StLoad;
      endcase
   end

   // FSM and sticky sequencing flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StLoad;
         cmd_q        <= '0;
         timer_q      <= '0;
         ack_err_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         timer_q      <= timer_d;
         ack_err_q    <= ack_err_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Capture statistics and protocol error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         write_count_q <= '0;
         checksum_q    <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         if (host_cmd_valid && !host_cmd_ready) proto_err_q <= 1'b1;
         if (!IRB_RW) begin
            write_count_q <= sat_inc7(write_count_q);
            checksum_q    <= checksum_q + {8'h00, IRB_D};
            if (!in_capture) proto_err_q <= 1'b1;
         end
      end
   end

   // Registered ROM read; a same-edge preload is seen on the next read
   always_ff @(posedge clk) begin
      if (reset) begin
         irom_data_q <= '0;
      end else if (!IROM_EN) begin
         irom_data_q <= img_q[IROM_A];
      end
   end

   // Image preload store, survives reset
   always_ff @(posedge clk) begin
      if (img_wr_en) img_q[img_wr_addr] <= img_wr_data;
   end

   // Capture store, written in every state and survives reset
   always_ff @(posedge clk) begin
      if (!IRB_RW) cap_q[IRB_A] <= IRB_D;
   end

   assign IROM_Q      = irom_data_q;
   assign cmd         = cmd_q;
   assign cmd_valid   = (state_q == StIssue);
   assign rd_data     = cap_q[rd_addr];
   assign write_count = write_count_q;
   assign checksum    = checksum_q;
   assign frame_done  = frame_done_q;
   assign frame_ok    = frame_done_q && (write_count_q == 7'd64);
   assign ack_err     = ack_err_q;
   assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_lcd_host_ctrl.sv
// Directed-sequence bench with randomized data against a behavioural host model.
module tb_lcd_host_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       img_wr_en;
   logic [5:0] img_wr_addr;
   logic [7:0] img_wr_data;
   logic [2:0] host_cmd;
   logic       host_cmd_valid;
   logic       host_cmd_ready;
   logic       IROM_EN;
   logic [5:0] IROM_A;
   logic [7:0] IROM_Q;
   logic       busy;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       IRB_RW;
   logic [5:0] IRB_A;
   logic [7:0] IRB_D;
   logic       done;
   logic [5:0] rd_addr;
   logic [7:0] rd_data;
   logic [6:0] write_count;
   logic [15:0] checksum;
   logic       frame_done;
   logic       frame_ok;
   logic       ack_err;
   logic       proto_err;

   always #5 clk = ~clk;

   lcd_host_ctrl #(
      .CMD_DEPTH   (16),
      .ACK_TIMEOUT (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .img_wr_en      (img_wr_en),
      .img_wr_addr    (img_wr_addr),
      .img_wr_data    (img_wr_data),
      .host_cmd       (host_cmd),
      .host_cmd_valid (host_cmd_valid),
      .host_cmd_ready (host_cmd_ready),
      .IROM_EN        (IROM_EN),
      .IROM_A         (IROM_A),
      .IROM_Q         (IROM_Q),
      .busy           (busy),
      .cmd            (cmd),
      .cmd_valid      (cmd_valid),
      .IRB_RW         (IRB_RW),
      .IRB_A          (IRB_A),
      .IRB_D          (IRB_D),
      .done           (done),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .write_count    (write_count),
      .checksum       (checksum),
      .frame_done     (frame_done),
      .frame_ok       (frame_ok),
      .ack_err        (ack_err),
      .proto_err      (proto_err)
   );

   int n_asserts = 0;
   int n_fail    = 0;
   int pulses    = 0;

   // Reference model state
   logic [7:0]  img_m [64];
   logic [7:0]  cap_m [64];
   logic [15:0] sum_m = 16'h0;
   int          cnt_m = 0;
   logic [2:0]  exp_q [$];

   // Count command strobes away from the active edge
   always @(negedge clk) begin
      if (cmd_valid === 1'b1) pulses <= pulses + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cap_write(input logic [5:0] a, input logic [7:0] d);
      IRB_RW = 1'b0;
      IRB_A  = a;
      IRB_D  = d;
      cap_m[a] = d;
      sum_m    = sum_m + 16'(d);
      if (cnt_m < 127) cnt_m++;
      tick();
      IRB_RW = 1'b1;
   endtask

   task automatic push(input logic [2:0] c);
      host_cmd       = c;
      host_cmd_valid = 1'b1;
      tick();
      host_cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sum_m = 16'h0;
      cnt_m = 0;
      exp_q.delete();
   endtask

   task automatic wait_strobe(output bit ok);
      int t = 0;
      while (cmd_valid !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      ok = (t < 100);
      chk("strobe_seen", 32'(ok), 32'(1));
   endtask

   // Act as LCD_CTRL: raise busy two cycles after each strobe, release unless writing
   task automatic serve(input int n);
      bit         ok;
      logic [2:0] e;
      for (int i = 0; i < n; i++) begin
         wait_strobe(ok);
         if (!ok) return;
         e = exp_q.pop_front();
         chk("cmd_value", 32'(cmd), 32'(e));
         tick();
         tick();
         busy = 1'b1;
         tick();
         repeat ($urandom_range(1, 3)) tick();
         if (e != 3'd0) busy = 1'b0;
      end
   endtask

   initial begin
      bit         ok;
      int         base;
      logic [7:0] d;
      logic [5:0] a;
      logic [2:0] c;

      reset          = 1'b1;
      img_wr_en      = 1'b0;
      img_wr_addr    = '0;
      img_wr_data    = '0;
      host_cmd       = '0;
      host_cmd_valid = 1'b0;
      IROM_EN        = 1'b1;
      IROM_A         = '0;
      busy           = 1'b1;
      IRB_RW         = 1'b1;
      IRB_A          = '0;
      IRB_D          = '0;
      done           = 1'b0;
      rd_addr        = '0;
      repeat (2) tick();
      reset = 1'b0;

      chk("rst_irom_q", 32'(IROM_Q), 32'(0));
      chk("rst_cmd", 32'(cmd), 32'(0));
      chk("rst_cmd_valid", 32'(cmd_valid), 32'(0));
      chk("rst_write_count", 32'(write_count), 32'(0));
      chk("rst_checksum", 32'(checksum), 32'(0));
      chk("rst_flags", 32'({frame_done, frame_ok, ack_err, proto_err}), 32'(0));
      chk("rst_ready", 32'(host_cmd_ready), 32'(1));

      // Preload img[i] = i, then sweep the ROM port
      for (int i = 0; i < 64; i++) begin
         img_wr_en   = 1'b1;
         img_wr_addr = 6'(i);
         img_wr_data = 8'(i);
         img_m[i]    = 8'(i);
         tick();
      end
      img_wr_en = 1'b0;
      IROM_EN   = 1'b0;
      for (int k = 0; k < 64; k++) begin
         IROM_A = 6'(k);
         tick();
         chk("irom_read", 32'(IROM_Q), 32'(img_m[k]));
      end
      IROM_EN = 1'b1;
      IROM_A  = 6'd9;
      repeat (2) tick();
      chk("irom_hold", 32'(IROM_Q), 32'(img_m[63]));

      // Preload and read of the same address on one edge returns the old pixel
      d           = 8'h80 | 8'($urandom);
      img_wr_en   = 1'b1;
      img_wr_addr = 6'd5;
      img_wr_data = d;
      IROM_EN     = 1'b0;
      IROM_A      = 6'd5;
      tick();
      chk("irom_collide_old", 32'(IROM_Q), 32'(img_m[5]));
      img_m[5]  = d;
      img_wr_en = 1'b0;
      tick();
      chk("irom_collide_new", 32'(IROM_Q), 32'(img_m[5]));
      IROM_EN = 1'b1;

      // Command sequence ending in a write command
      base = pulses;
      busy = 1'b0;
      repeat (2) tick();
      busy = 1'b1;
      exp_q.push_back(3'd4);
      exp_q.push_back(3'd5);
      exp_q.push_back(3'($urandom_range(1, 7)));
      exp_q.push_back(3'($urandom_range(1, 7)));
      exp_q.push_back(3'd0);
      for (int i = 0; i < 5; i++) push(exp_q[i]);
      repeat (3) tick();
      chk("no_issue_while_busy", 32'(pulses - base), 32'(0));
      busy = 1'b0;
      serve(5);
      chk("pulse_count_5", 32'(pulses - base), 32'(5));
      chk("ack_err_clean", 32'(ack_err), 32'(0));
      chk("ready_low_capture", 32'(host_cmd_ready), 32'(0));
      chk("proto_err_clean", 32'(proto_err), 32'(0));

      // Full frame, done coincident with the last write
      for (int k = 0; k < 64; k++) begin
         if (k == 63) done = 1'b1;
         cap_write(6'(k), 8'hFF);
      end
      done = 1'b0;
      chk("frame_count", 32'(write_count), 32'(cnt_m));
      chk("frame_checksum", 32'(checksum), 32'(sum_m));
      chk("frame_checksum_abs", 32'(checksum), 32'(16'h3FC0));
      chk("frame_done", 32'(frame_done), 32'(1));
      chk("frame_ok", 32'(frame_ok), 32'(1));
      for (int i = 0; i < 4; i++) begin
         rd_addr = 6'($urandom_range(0, 63));
         #1;
         chk("rd_data_ff", 32'(rd_data), 32'(cap_m[rd_addr]));
      end

      // Random overwrites in DONE until the counter saturates
      cap_write(6'($urandom_range(0, 63)), 8'($urandom));
      chk("frame_ok_65", 32'(frame_ok), 32'(0));
      for (int i = 0; i < 69; i++) cap_write(6'($urandom_range(0, 63)), 8'($urandom));
      chk("count_saturated", 32'(write_count), 32'(cnt_m));
      chk("checksum_random", 32'(checksum), 32'(sum_m));
      chk("done_no_proto_err", 32'(proto_err), 32'(0));
      chk("frame_done_sticky", 32'(frame_done), 32'(1));
      for (int i = 0; i < 8; i++) begin
         rd_addr = 6'($urandom_range(0, 63));
         #1;
         chk("rd_data_rand", 32'(rd_data), 32'(cap_m[rd_addr]));
      end

      // Pushes are refused in DONE
      base = pulses;
      push(3'($urandom_range(0, 7)));
      repeat (4) tick();
      chk("done_push_proto_err", 32'(proto_err), 32'(1));
      chk("done_no_strobe", 32'(pulses - base), 32'(0));

      // Fill the queue while LCD is still busy fetching
      busy = 1'b1;
      do_reset();
      chk("rst2_count", 32'(write_count), 32'(0));
      chk("rst2_checksum", 32'(checksum), 32'(0));
      chk("rst2_flags", 32'({frame_done, ack_err, proto_err}), 32'(0));
      chk("rst2_ready", 32'(host_cmd_ready), 32'(1));
      base = pulses;
      for (int i = 0; i < 16; i++) begin
         c = 3'($urandom_range(1, 7));
         exp_q.push_back(c);
         push(c);
      end
      chk("full_ready_low", 32'(host_cmd_ready), 32'(0));
      chk("full_no_err_yet", 32'(proto_err), 32'(0));
      push(3'($urandom_range(1, 7)));
      chk("full_drop_proto_err", 32'(proto_err), 32'(1));
      chk("load_no_strobe", 32'(pulses - base), 32'(0));
      busy = 1'b0;
      serve(16);
      chk("pulse_count_16", 32'(pulses - base), 32'(16));
      chk("ack_err_clean2", 32'(ack_err), 32'(0));

      // LCD never acknowledges the first command
      busy = 1'b1;
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd3);
      push(3'd1);
      push(3'd3);
      busy = 1'b0;
      wait_strobe(ok);
      c = exp_q.pop_front();
      chk("timeout_cmd", 32'(cmd), 32'(c));
      tick();
      base = pulses;
      repeat (6) tick();
      chk("ack_err_early", 32'(ack_err), 32'(0));
      chk("no_strobe_in_ack", 32'(pulses - base), 32'(0));
      repeat (3) tick();
      chk("ack_err_set", 32'(ack_err), 32'(1));
      serve(1);

      // Reset in the middle of a capture
      do_reset();
      busy = 1'b0;
      repeat (2) tick();
      busy = 1'b1;
      exp_q.push_back(3'd0);
      push(3'd0);
      busy = 1'b0;
      serve(1);
      for (int i = 0; i < 10; i++) cap_write(6'($urandom_range(0, 63)), 8'($urandom));
      a = IRB_A;
      chk("mid_count", 32'(write_count), 32'(cnt_m));
      chk("mid_checksum", 32'(checksum), 32'(sum_m));
      do_reset();
      chk("mid_rst_cmd_valid", 32'(cmd_valid), 32'(0));
      chk("mid_rst_count", 32'(write_count), 32'(0));
      chk("mid_rst_checksum", 32'(checksum), 32'(0));
      chk("mid_rst_ready", 32'(host_cmd_ready), 32'(1));
      rd_addr = a;
      #1;
      chk("cap_survives_reset", 32'(rd_data), 32'(cap_m[a]));
      base = pulses;
      push(3'($urandom_range(1, 7)));
      repeat (5) tick();
      chk("mid_rst_load_waits", 32'(pulses - base), 32'(0));

      // IRB write outside capture is kept but flagged
      d = 8'($urandom);
      cap_write(6'd7, d);
      rd_addr = 6'd7;
      #1;
      chk("stray_write_proto_err", 32'(proto_err), 32'(1));
      chk("stray_write_count", 32'(write_count), 32'(cnt_m));
      chk("stray_write_data", 32'(rd_data), 32'(cap_m[7]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
